// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: op codes, FSM states and
// the per-operation context latched at accept time.
package div_unit_pkg;

  localparam logic [3:0] OP_DIV  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_REM  = 4'b1110;
  localparam logic [3:0] OP_REMU = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  // What the FIX step needs to turn the unsigned core output into a result.
  typedef struct packed {
    logic rem_sel;  // 1: remainder, 0: quotient
    logic neg_q;    // quotient must be negated
    logic neg_r;    // remainder must be negated
  } div_ctx_t;

  // Two's-complement negate when neg is set.
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/divu_core.sv
// Unsigned restoring divider datapath: one quotient bit per step, MSB first.
// The quotient register doubles as the dividend shift register.
module divu_core #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem,
  output logic         last
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  quot_q, rem_q, dvs_q;
  logic [CW-1:0] cnt_q;
  logic [W:0]    part, diff;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign part = {rem_q, quot_q[W-1]};
  assign diff = part - {1'b0, dvs_q};

  // Load operands on accept, then one restoring step per enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      quot_q <= dividend;
      rem_q  <= '0;
      dvs_q  <= divisor;
      cnt_q  <= CW'(W - 1);
    end else if (step) begin
      rem_q  <= diff[W] ? part[W-1:0] : diff[W-1:0];
      quot_q <= {quot_q[W-2:0], ~diff[W]};
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q;
  assign last = (cnt_q == '0);

endmodule

// File: rtl/div_unit.sv
// EX-stage multi-cycle divider for DIV/DIVU/REM/REMU. Owns the control FSM,
// sign handling, special cases and result register; the unsigned
// shift/subtract work is done in divu_core.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] opr_1,
  input  logic [XLEN-1:0] opr_2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  div_state_e state_q, state_d;
  div_ctx_t   ctx_q, ctx_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            result_ld;

  logic            accept, is_signed, s1, s2, div0, ovf, special;
  logic [XLEN-1:0] mag1, mag2, spec_res, fix_res;
  logic            core_load, core_step, core_last;
  logic [XLEN-1:0] core_quot, core_rem;

  // Decode the request and prepare magnitudes / special-case results.
  assign accept    = start && (state_q == ST_IDLE) && (alu_op[3:2] == OP_DIV[3:2]);
  assign is_signed = ~alu_op[0];
  assign s1        = is_signed & opr_1[XLEN-1];
  assign s2        = is_signed & opr_2[XLEN-1];
  assign mag1      = cond_neg(opr_1, s1);
  assign mag2      = cond_neg(opr_2, s2);
  assign div0      = (opr_2 == '0);
  assign ovf       = is_signed && (opr_1 == 32'h8000_0000) && (opr_2 == 32'hFFFF_FFFF);
  assign special   = div0 | ovf;
  assign spec_res  = div0 ? (alu_op[1] ? opr_1 : 32'hFFFF_FFFF)
                          : (alu_op[1] ? 32'h0 : 32'h8000_0000);
  assign fix_res   = ctx_q.rem_sel ? cond_neg(core_rem, ctx_q.neg_r)
                                   : cond_neg(core_quot, ctx_q.neg_q);

  assign ctx_d.rem_sel = alu_op[1];
  assign ctx_d.neg_q   = s1 ^ s2;
  assign ctx_d.neg_r   = s1;

  divu_core #(.W(XLEN)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .step     (core_step),
    .dividend (mag1),
    .divisor  (mag2),
    .quot     (core_quot),
    .rem      (core_rem),
    .last     (core_last)
  );

  // Next-state, core control and result-load decisions.
  always_comb begin
    state_d   = state_q;
    core_load = 1'b0;
    core_step = 1'b0;
    result_ld = 1'b0;
    result_d  = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (special) begin
            state_d   = ST_DONE;
            result_ld = 1'b1;
            result_d  = spec_res;
          end else begin
            state_d   = ST_CALC;
            core_load = 1'b1;
          end
        end
      end
      ST_CALC: begin
        core_step = 1'b1;
        if (core_last) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d   = ST_DONE;
        result_ld = 1'b1;
        result_d  = fix_res;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched op context and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ctx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept)    ctx_q    <= ctx_d;
      if (result_ld) result_q <= result_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule
